tiny_pattern_generator: RTL and testbench
=========================================

TINY_PATTERN_GENERATOR -- requirements
Module: tiny_pattern_generator

Interface
REQ-001 Parameter PAT_W, default 8, pattern length in bits (range 2..16).
REQ-002 Parameter RATE_W, default 3, width of the rate select (bit period 2^rate clocks).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 run  input  1  level; high requests pattern playback.
REQ-006 cfg_load  input  1  level; high enables serial pattern shift-in.
REQ-007 cfg_data  input  1  serial pattern bit, MSB first.
REQ-008 rate  input  RATE_W  bit-period select.
REQ-009 dout  output  1  generated waveform, registered.
REQ-010 frame  output  1  one-clk pulse coincident with the first bit of every pattern repetition, registered.
REQ-011 running  output  1  high while state is RUN.
REQ-012 pending  output  1  high while a committed pattern waits for the next frame boundary.

Function
REQ-013 run, cfg_load and cfg_data SHALL each pass a 2-flop synchronizer (s_run, s_load, s_data); rate is sampled unsynchronized at latch points only.
REQ-014 Input pin change SHALL take effect at the 3rd rising clk edge after it (2 sync + 1 action).
REQ-015 Registers: shadow[PAT_W], active[PAT_W], idx (bit index), cnt (2^RATE_W-1 max), rate_q, state {IDLE, RUN}, pending.
REQ-016 Shift-in, any state: each edge with s_load=1 SHALL do shadow <= {shadow[PAT_W-2:0], s_data}; no bit count tracked, surplus bits fall off the MSB.
REQ-017 Commit: edge where s_load goes 1->0; in IDLE active <= shadow on that edge; in RUN pending <= 1 and active unchanged.
REQ-018 IDLE: dout=0, frame=0, cnt=0, idx=PAT_W-1.
REQ-019 IDLE->RUN on edge with s_run=1 and s_load=0: idx <= PAT_W-1, cnt <= 0, rate_q <= rate, dout <= pattern[PAT_W-1], frame <= 1.
REQ-020 If commit and RUN entry coincide, "pattern" in REQ-019 SHALL be the newly committed shadow.
REQ-021 In IDLE with s_load=1, run SHALL be ignored (load has priority).
REQ-022 RUN, per edge: if cnt == 2^rate_q - 1 then cnt <= 0 and step bit, else cnt <= cnt+1 and frame <= 0; each bit held exactly 2^rate_q clocks.
REQ-023 Step: idx>0 -> idx <= idx-1, dout <= active[idx-1], frame <= 0.
REQ-024 Wrap (step at idx==0): idx <= PAT_W-1, rate_q <= rate, frame <= 1; if pending, active <= shadow, dout <= shadow[PAT_W-1], pending <= 0; else dout <= active[PAT_W-1].
REQ-025 rate changes SHALL only take effect at RUN entry or wrap.
REQ-026 RUN->IDLE on any edge with s_run=0, mid-bit or mid-frame: dout <= 0, frame <= 0, cnt <= 0; pending SHALL then commit: active <= shadow, pending <= 0 on the same edge.
REQ-027 Shift-in during RUN SHALL NOT alter dout or active until wrap.
REQ-028 Second commit while pending=1 SHALL simply keep pending=1; latest shadow wins at wrap.
REQ-029 running = (state==RUN), combinational from state register.

Reset
REQ-030 rst=1 SHALL immediately force: state IDLE, shadow=0, active=0, idx=PAT_W-1, cnt=0, rate_q=0, pending=0, sync flops 0, dout=0, frame=0, running=0.
REQ-031 After rst release with run held high, RUN SHALL start at the 3rd edge, playing pattern 0 (dout stays 0, frame still pulses).

Verification
REQ-032 Reset: assert rst mid-run -> dout=0, frame=0, running=0, pending=0 same cycle, without clock.
REQ-033 Load 8'hA5 (cfg_load high 8 clk), rate=0, run=1 -> dout 1,0,1,0,0,1,0,1 one clk each, repeating; frame every 8 clk on first bit.
REQ-034 Same pattern, rate=2 -> each bit held 4 clk, frame period 32 clk; changing rate to 0 mid-frame changes period only after next frame pulse.
REQ-035 Running 8'hA5, shift in 8'h0F mid-frame -> pending=1, A5 frame completes intact, next frame outputs 0,0,0,0,1,1,1,1, pending=0 at that frame pulse.
REQ-036 Deassert run at bit 3 of frame -> running=0 and dout=0 on 3rd edge after run fall; reassert -> restarts from MSB with frame=1.
REQ-037 Shift in 10 bits 1,1,0,0,0,0,0,0,1,1 in IDLE -> active=8'h03 (first two dropped); coincident commit+run plays 8'h03 from first bit.

Source files
------------

// File: rtl/tiny_pattern_generator.sv
// Serially loaded pattern generator: replays a PAT_W-bit pattern MSB first,
// each bit held 2^rate clocks, with a frame pulse on the first bit of every repetition.
module tiny_pattern_generator #(
  parameter int PAT_W  = 8,
  parameter int RATE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              cfg_load,
  input  logic              cfg_data,
  input  logic [RATE_W-1:0] rate,
  output logic              dout,
  output logic              frame,
  output logic              running,
  output logic              pending
);
  localparam int IDX_W = $clog2(PAT_W);
  localparam int CNT_W = (1 << RATE_W) - 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [1:0]         run_sync_q, run_sync_d;
  logic [1:0]         load_sync_q, load_sync_d;
  logic [1:0]         data_sync_q, data_sync_d;
  logic               load_prev_q, load_prev_d;
  logic [PAT_W-1:0]   shadow_q, shadow_d;
  logic [PAT_W-1:0]   active_q, active_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RATE_W-1:0]  rate_q, rate_d;
  logic               pending_q, pending_d;
  logic               dout_q, dout_d;
  logic               frame_q, frame_d;

  logic s_run, s_load, s_data, commit, start, cnt_last;
  logic [IDX_W-1:0] idx_dec;

  assign s_run    = run_sync_q[1];
  assign s_load   = load_sync_q[1];
  assign s_data   = data_sync_q[1];
  assign commit   = load_prev_q & ~s_load;
  // Load has priority over run while in IDLE.
  assign start    = (state_q == IDLE) & s_run & ~s_load;
  assign cnt_last = (cnt_q == CNT_W'((32'd1 << rate_q) - 32'd1));
  assign idx_dec  = idx_q - IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      run_sync_q  <= '0;
      load_sync_q <= '0;
      data_sync_q <= '0;
      load_prev_q <= 1'b0;
      shadow_q    <= '0;
      active_q    <= '0;
      idx_q       <= IDX_TOP;
      cnt_q       <= '0;
      rate_q      <= '0;
      pending_q   <= 1'b0;
      dout_q      <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_sync_q  <= run_sync_d;
      load_sync_q <= load_sync_d;
      data_sync_q <= data_sync_d;
      load_prev_q <= load_prev_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rate_q      <= rate_d;
      pending_q   <= pending_d;
      dout_q      <= dout_d;
      frame_q     <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!s_run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_sync_d  = {run_sync_q[0], run};
    load_sync_d = {load_sync_q[0], cfg_load};
    data_sync_d = {data_sync_q[0], cfg_data};
    load_prev_d = s_load;
    shadow_d    = shadow_q;
    active_d    = active_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rate_d      = rate_q;
    pending_d   = pending_q;
    dout_d      = dout_q;
    frame_d     = frame_q;

    if (s_load) shadow_d = {shadow_q[PAT_W-2:0], s_data};

    case (state_q)
      IDLE: begin
        dout_d  = 1'b0;
        frame_d = 1'b0;
        cnt_d   = '0;
        idx_d   = IDX_TOP;
        if (commit) active_d = shadow_q;
        if (start) begin
          rate_d  = rate;
          dout_d  = commit ? shadow_q[PAT_W-1] : active_q[PAT_W-1];
          frame_d = 1'b1;
        end
      end
      RUN: begin
        if (commit) pending_d = 1'b1;
        if (!s_run) begin
          dout_d  = 1'b0;
          frame_d = 1'b0;
          cnt_d   = '0;
          idx_d   = IDX_TOP;
          // A commit still waiting for a frame boundary lands on the way out.
          if (pending_q || commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
          end
        end else if (cnt_last) begin
          cnt_d = '0;
          if (idx_q != '0) begin
            idx_d   = idx_dec;
            dout_d  = active_q[idx_dec];
            frame_d = 1'b0;
          end else begin
            idx_d   = IDX_TOP;
            rate_d  = rate;
            frame_d = 1'b1;
            if (pending_q) begin
              active_d  = shadow_q;
              dout_d    = shadow_q[PAT_W-1];
              pending_d = 1'b0;
            end else begin
              dout_d = active_q[PAT_W-1];
            end
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          frame_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign dout    = dout_q;
  assign frame   = frame_q;
  assign pending = pending_q;
  assign running = (state_q == RUN);
endmodule

// File: tb/tb_tiny_pattern_generator.sv
// Bench for tiny_pattern_generator: a frame-position model checked every cycle,
// plus literal pattern/period/latency checks from directed scenarios.
module tb_tiny_pattern_generator;
  localparam int PAT_W  = 8;
  localparam int RATE_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              run = 1'b0;
  logic              cfg_load = 1'b0;
  logic              cfg_data = 1'b0;
  logic [RATE_W-1:0] rate = '0;
  logic              dout, frame, running, pending;

  int errors = 0;
  int checks = 0;

  tiny_pattern_generator #(.PAT_W(PAT_W), .RATE_W(RATE_W)) dut (
    .clk(clk), .rst(rst), .run(run), .cfg_load(cfg_load), .cfg_data(cfg_data),
    .rate(rate), .dout(dout), .frame(frame), .running(running), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: pins reach the logic two edges late; playback is tracked as a
  // position within the frame rather than a bit index and hold counter.
  logic [1:0]       run_h, load_h, data_h;
  logic             m_prev_load, m_on, m_pend, m_dout, m_frame;
  logic [PAT_W-1:0] m_shadow, m_active;
  int               m_pos, m_rate;

  task automatic model_reset();
    run_h = '0; load_h = '0; data_h = '0;
    m_prev_load = 0; m_on = 0; m_pend = 0; m_dout = 0; m_frame = 0;
    m_shadow = '0; m_active = '0; m_pos = 0; m_rate = 0;
  endtask

  task automatic model_step();
    logic s_run, s_load, s_data, commit, pend_old;
    s_run = run_h[1]; s_load = load_h[1]; s_data = data_h[1];
    run_h = {run_h[0], run}; load_h = {load_h[0], cfg_load}; data_h = {data_h[0], cfg_data};
    commit = m_prev_load && !s_load;
    m_prev_load = s_load;
    pend_old = m_pend;
    if (!m_on) begin
      m_dout = 0; m_frame = 0;
      if (commit) m_active = m_shadow;
      if (s_run && !s_load) begin
        m_on = 1; m_pos = 0; m_rate = int'(rate);
        m_dout = m_active[PAT_W-1]; m_frame = 1;
      end
    end else if (!s_run) begin
      m_on = 0; m_dout = 0; m_frame = 0;
      if (pend_old || commit) begin m_active = m_shadow; m_pend = 0; end
    end else begin
      m_pend = pend_old || commit;
      m_pos++;
      m_frame = 0;
      if (m_pos == (PAT_W << m_rate)) begin
        m_pos = 0; m_rate = int'(rate); m_frame = 1;
        if (pend_old) begin m_active = m_shadow; m_pend = 0; end
      end
      m_dout = m_active[PAT_W-1 - (m_pos >> m_rate)];
    end
    if (s_load) m_shadow = {m_shadow[PAT_W-2:0], s_data};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("model_dout", dout, m_dout);
        check("model_frame", frame, m_frame);
        check("model_running", running, m_on);
        check("model_pending", pending, m_pend);
      end
    end
  end

  task automatic wait_frame(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame === 1'b1) return;
    end
    checks++; errors++;
    $display("FAIL %s: no frame pulse within 400 cycles (got none, required one)", name);
  endtask

  // Called on the negedge showing a frame pulse; samples each bit once.
  task automatic collect_bits(input int period, output logic [7:0] v);
    v[7] = dout;
    for (int b = 6; b >= 0; b--) begin
      repeat (period) @(negedge clk);
      v[b] = dout;
    end
  endtask

  task automatic measure_period(input int change_at, input int new_rate, output int n);
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == change_at) rate = RATE_W'(new_rate);
      if (frame === 1'b1) begin n = i; return; end
    end
  endtask

  task automatic shift_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      cfg_load = 1'b1;
      cfg_data = bits[i];
    end
    @(negedge clk);
    cfg_load = 1'b0;
    cfg_data = 1'b0;
  endtask

  logic [7:0] v;
  int         n;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_dout", dout, 0);
    check("reset_running", running, 0);
    check("reset_pending", pending, 0);

    // A5 at rate 0; commit and run entry land on the same edge
    shift_bits(16'h00A5, 8);
    run = 1'b1;
    repeat (2) @(negedge clk);
    check("entry_not_yet", running, 0);
    @(negedge clk);
    check("entry_frame", frame, 1);
    check("entry_running", running, 1);
    collect_bits(1, v);
    check("a5_rate0_bits", v, 8'hA5);
    wait_frame("a5_wait");
    measure_period(0, 0, n);
    check("a5_rate0_period", n, 8);

    // rate 2 latched at the next wrap; a mid-frame change waits for the frame end
    rate = 3'd2;
    wait_frame("rate2_wait");
    collect_bits(4, v);
    check("a5_rate2_bits", v, 8'hA5);
    wait_frame("rate2_wait2");
    measure_period(5, 0, n);
    check("rate2_period_after_change", n, 32);
    measure_period(0, 0, n);
    check("rate0_period_restored", n, 8);

    // New pattern committed mid-frame stays pending until the wrap
    rate = 3'd2;
    wait_frame("pend_wait");
    repeat (2) @(negedge clk);
    shift_bits(16'h000F, 8);
    repeat (3) @(negedge clk);
    check("pend_set", pending, 1);
    wait_frame("pend_wrap");
    check("pend_clear", pending, 0);
    collect_bits(4, v);
    check("0f_rate2_bits", v, 8'h0F);

    // Stop mid-frame, then restart from MSB
    rate = 3'd0;
    wait_frame("stop_wait");
    repeat (3) @(negedge clk);
    run = 1'b0;
    @(negedge clk); check("stop_edge1_running", running, 1);
    @(negedge clk); check("stop_edge2_running", running, 1);
    @(negedge clk); check("stop_edge3_running", running, 0);
    check("stop_dout", dout, 0);
    run = 1'b1;
    repeat (2) @(negedge clk);
    check("restart_edge2_running", running, 0);
    @(negedge clk);
    check("restart_running", running, 1);
    check("restart_frame", frame, 1);
    check("restart_dout_msb", dout, 0);
    collect_bits(1, v);
    check("0f_restart_bits", v, 8'h0F);

    // Ten bits into an idle shadow: the first two fall off the MSB
    run = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(16'b11_0000_0011, 10);
    run = 1'b1;
    repeat (3) @(negedge clk);
    check("overflow_entry_frame", frame, 1);
    collect_bits(1, v);
    check("overflow_bits", v, 8'h03);

    // Asynchronous reset while running with a pattern pending
    shift_bits(16'h0003, 2);
    repeat (3) @(negedge clk);
    check("pre_rst_pending", pending, 1);
    check("pre_rst_running", running, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dout", dout, 0);
    check("async_rst_frame", frame, 0);
    check("async_rst_running", running, 0);
    check("async_rst_pending", pending, 0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
